// File: rtl/rv_pkg.sv
// Shared register-file constants for the write-back slice.
//   XLEN        default datapath width
//   REG_ADDR_W  register index width
//   NUM_REGS    architectural register count
//   X0          hard-wired zero register index
//   reg_onehot  one-hot mask for a register index
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with occupancy count; holds load results until they win
// the register-file write port.
//   clk, reset       clock, synchronous active-low reset (flushes contents)
//   push, push_data  enqueue request (ignored when full)
//   pop              dequeue request (ignored when empty)
//   head_data        entry at the head, valid when !empty
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
module wb_sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Write-side initiator for the 32x32 register file. Arbitrates ALU results
// and buffered load results onto the single write port, tracks registers with
// an outstanding load (decode stall) and flags same-cycle bypass for the two
// async read ports.
//   clk, reset                    clock, synchronous active-low reset
//   alu_valid/ready/rd/data       ALU result handshake
//   lsu_valid/ready/rd/data       load result handshake into the load FIFO
//   ld_issue, ld_issue_rd         load issued; marks its destination busy
//   dec_valid/rs1/rs2/rd          decode operands checked against busy set
//   dec_stall                     decode must hold
//   fwd1_en, fwd2_en              bypass rg_wrt_data to read port 1 / 2
//   rg_wrt_en/addr/data           register file write port (registered)
//   lq_count                      load FIFO occupancy
module rf_writeback_unit #(
  parameter int unsigned LQ_DEPTH = 4,
  parameter int unsigned XLEN     = rv_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_rd,
  input  logic [XLEN-1:0]            lsu_data,
  input  logic                       ld_issue,
  input  logic [4:0]                 ld_issue_rd,
  input  logic                       dec_valid,
  input  logic [4:0]                 dec_rs1,
  input  logic [4:0]                 dec_rs2,
  input  logic [4:0]                 dec_rd,
  output logic                       dec_stall,
  output logic                       fwd1_en,
  output logic                       fwd2_en,
  output logic                       rg_wrt_en,
  output logic [4:0]                 rg_wrt_addr,
  output logic [XLEN-1:0]            rg_wrt_data,
  output logic [$clog2(LQ_DEPTH):0]  lq_count
);

  import rv_pkg::*;

  localparam int unsigned ENT_W = REG_ADDR_W + XLEN;

  logic                  lq_push;
  logic                  lq_pop;
  logic [ENT_W-1:0]      lq_head;
  logic                  lq_full;
  logic                  lq_empty;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;

  logic                  win_valid;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  wb_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (lq_push),
    .push_data ({lsu_rd, lsu_data}),
    .pop       (lq_pop),
    .head_data (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  assign head_rd   = lq_head[XLEN +: REG_ADDR_W];
  assign head_data = lq_head[XLEN-1:0];

  assign lsu_ready = !lq_full;
  assign alu_ready = !lq_full;
  assign lq_push   = lsu_valid && !lq_full;

  // A full FIFO takes priority so the ALU can never starve loads forever;
  // otherwise the ALU wins and loads drain in idle ALU cycles.
  always_comb begin
    win_valid = 1'b0;
    win_rd    = X0;
    win_data  = '0;
    lq_pop    = 1'b0;
    if (lq_full) begin
      lq_pop    = 1'b1;
      win_valid = 1'b1;
      win_rd    = head_rd;
      win_data  = head_data;
    end else if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end else if (!lq_empty) begin
      lq_pop    = 1'b1;
      win_valid = 1'b1;
      win_rd    = head_rd;
      win_data  = head_data;
    end
  end

  // Address/data hold when nothing is written; bypass is gated by rg_wrt_en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
    end else begin
      rg_wrt_en <= win_valid && (win_rd != X0);
      if (win_valid && (win_rd != X0)) begin
        rg_wrt_addr <= win_rd;
        rg_wrt_data <= win_data;
      end
    end
  end

  // Clear applied before set so a new load to the same rd keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (lq_pop && (head_rd != X0)) begin
      busy_d = busy_d & ~reg_onehot(head_rd);
    end
    if (ld_issue && (ld_issue_rd != X0)) begin
      busy_d = busy_d | reg_onehot(ld_issue_rd);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign dec_stall = dec_valid && (busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd]);

  assign fwd1_en = rg_wrt_en && (rg_wrt_addr == dec_rs1) && (dec_rs1 != X0);
  assign fwd2_en = rg_wrt_en && (rg_wrt_addr == dec_rs2) && (dec_rs2 != X0);

endmodule

// File: tb/tb_rf_writeback_unit.sv
module tb_rf_writeback_unit;

  localparam int unsigned LQ_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall, fwd1_en, fwd2_en;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic [2:0]  lq_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model state
  ent_t        m_fifo[$];
  ent_t        exp_q[$];
  logic [4:0]  outstanding[$];
  logic [31:0] m_busy = '0;
  bit          m_wr_en = 1'b0;
  logic [4:0]  m_wr_addr = '0;

  always #5 clk = ~clk;

  rf_writeback_unit #(
    .LQ_DEPTH (LQ_DEPTH),
    .XLEN     (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_stall   (dec_stall),
    .fwd1_en     (fwd1_en),
    .fwd2_en     (fwd2_en),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .lq_count    (lq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Checks outputs mid-cycle, then advances the model across the next edge.
  always @(negedge clk) begin
    ent_t       head, e;
    bit         full, pop, win;
    logic [4:0] wrd;
    logic [31:0] wdat;
    if (chk_en) begin
      chk("rg_wrt_en", rg_wrt_en, m_wr_en);
      if (rg_wrt_en) begin
        if (exp_q.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rg_wrt_addr", rg_wrt_addr, e.rd);
          chk("rg_wrt_data", rg_wrt_data, e.data);
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      chk("lq_count", lq_count, m_fifo.size());
      chk("alu_ready", alu_ready, m_fifo.size() != LQ_DEPTH);
      chk("lsu_ready", lsu_ready, m_fifo.size() != LQ_DEPTH);
      chk("dec_stall", dec_stall,
          dec_valid && (m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd]));
      chk("fwd1_en", fwd1_en, m_wr_en && m_wr_addr == dec_rs1 && dec_rs1 != 0);
      chk("fwd2_en", fwd2_en, m_wr_en && m_wr_addr == dec_rs2 && dec_rs2 != 0);
    end
    if (!reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_busy    = '0;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
    end else begin
      full = (m_fifo.size() == LQ_DEPTH);
      pop  = 1'b0;
      win  = 1'b0;
      wrd  = '0;
      wdat = '0;
      head = '0;
      if (full || (!alu_valid && m_fifo.size() > 0)) begin
        head = m_fifo.pop_front();
        pop  = 1'b1;
        win  = 1'b1;
        wrd  = head.rd;
        wdat = head.data;
      end else if (alu_valid) begin
        win  = 1'b1;
        wrd  = alu_rd;
        wdat = alu_data;
      end
      if (lsu_valid && !full) begin
        m_fifo.push_back('{rd: lsu_rd, data: lsu_data});
        if (outstanding.size() > 0) void'(outstanding.pop_front());
      end
      if (pop && head.rd != 0) m_busy[head.rd] = 1'b0;
      if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
      m_wr_en = win && (wrd != 0);
      if (m_wr_en) begin
        m_wr_addr = wrd;
        exp_q.push_back('{rd: wrd, data: wdat});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    ld_issue  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    idle();
    while ((m_fifo.size() > 0 || exp_q.size() > 0) && n < 50) begin
      step();
      n++;
    end
    if (m_fifo.size() > 0 || exp_q.size() > 0) chk(tag, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] r;
    reset = 1'b0;
    idle();
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0; ld_issue_rd = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    step();
    step();
    reset  = 1'b1;
    chk_en = 1'b1;
    chk("reset_addr", rg_wrt_addr, 0);
    chk("reset_data", rg_wrt_data, 0);
    chk("reset_count", lq_count, 0);

    // ALU write with empty FIFO
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    chk("alu_wr_en", rg_wrt_en, 1);
    chk("alu_wr_data", rg_wrt_data, 32'hDEADBEEF);
    step();

    // load to x7 stalls a reader of x7 until popped
    ld_issue = 1'b1; ld_issue_rd = 7;
    step();
    idle();
    dec_valid = 1'b1; dec_rs1 = 7; dec_rs2 = 3; dec_rd = 8;
    #1 chk("raw_stall", dec_stall, 1);
    step();
    step();
    lsu_valid = 1'b1; lsu_rd = 7; lsu_data = 32'h0000AAAA;
    step();
    idle();
    step();
    chk("stall_released", dec_stall, 0);
    dec_valid = 1'b0;
    drain("drain_raw");

    // four loads buffered while ALU holds the port
    for (int unsigned i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(i);
      step();
    end
    idle();
    for (int unsigned i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(i);      lsu_data = 32'hB000 + i;
      step();
    end
    lsu_valid = 1'b0;
    chk("full_count", lq_count, 4);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_lsu_ready", lsu_ready, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      alu_rd = 5'(20 + i); alu_data = 32'hC000 + i;
      step();
    end
    drain("drain_full");

    // x0 destination is accepted but never written
    alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h1234;
    #1 chk("x0_alu_ready", alu_ready, 1);
    step();
    idle();
    chk("x0_no_write", rg_wrt_en, 0);
    step();

    // bypass from write port to decode
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h99;
    step();
    idle();
    dec_valid = 1'b1; dec_rs1 = 9; dec_rs2 = 0; dec_rd = 1;
    #1 chk("fwd1_hit", fwd1_en, 1);
    chk("fwd2_x0", fwd2_en, 0);
    step();
    dec_valid = 1'b0;

    // reset discards buffered loads and busy bits
    for (int unsigned i = 0; i < 3; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(11 + i);
      step();
    end
    idle();
    for (int unsigned i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(2 + i); alu_data = 32'hD000 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(11 + i); lsu_data = 32'hE000 + i;
      step();
    end
    idle();
    chk("pre_reset_count", lq_count, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_count", lq_count, 0);
    chk("rst_wr_en", rg_wrt_en, 0);
    dec_valid = 1'b1; dec_rs1 = 11; dec_rs2 = 12; dec_rd = 13;
    #1 chk("rst_busy_clear", dec_stall, 0);
    step();
    dec_valid = 1'b0;

    // random traffic; one outstanding load per rd
    for (int unsigned c = 0; c < 400; c++) begin
      idle();
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      r = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 2) == 0 && !m_busy[r] && outstanding.size() < 6) begin
        ld_issue = 1'b1; ld_issue_rd = r;
        outstanding.push_back(r);
      end
      if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        lsu_valid = 1'b1; lsu_rd = outstanding[0]; lsu_data = $urandom;
      end
      dec_valid = 1'($urandom_range(0, 1));
      dec_rs1 = 5'($urandom_range(0, 31));
      dec_rs2 = 5'($urandom_range(0, 31));
      dec_rd  = 5'($urandom_range(0, 31));
      step();
    end
    for (int unsigned c = 0; c < 40 && outstanding.size() > 0; c++) begin
      idle();
      lsu_valid = 1'b1; lsu_rd = outstanding[0]; lsu_data = $urandom;
      step();
    end
    if (outstanding.size() > 0) chk("outstanding_timeout", 1, 0);
    dec_valid = 1'b0;
    drain("drain_random");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
